// File: rtl/ahb_rr_output_arbiter_if.sv
// Signal bundle between one bus-matrix output stage and its round-robin arbiter.
// The master side drives requests and output-port bus state. The slave side (the arbiter) returns the grant.
interface ahb_rr_output_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold
    );
endinterface

// File: rtl/ahb_rr_output_arbiter.sv
// Round-robin output-stage arbiter for a shared bus-matrix slave port.
// The grant is frozen during fixed-length bursts, locked sequences and wait states.
module ahb_rr_output_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    ahb_rr_output_arbiter_if.slave    bus
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_WRAP4  = 3'b010;
    localparam logic [2:0] BU_INCR4  = 3'b011;
    localparam logic [2:0] BU_WRAP8  = 3'b100;
    localparam logic [2:0] BU_INCR8  = 3'b101;
    localparam logic [2:0] BU_WRAP16 = 3'b110;
    localparam logic [2:0] BU_INCR16 = 3'b111;

    logic [3:0]        r_cnt;
    logic              r_hold;
    logic [PORT_W-1:0] r_addr;
    logic              r_no_port;

    logic [3:0]        w_cnt_nxt;
    logic              w_hold_nxt;
    logic [PORT_W-1:0] w_addr_nxt;
    logic              w_no_port_nxt;
    logic [PORT_W-1:0] w_rr_idx;
    logic              w_rr_found;
    int                w_cand;

    // State register: reset wins over HREADYM, and the grant only moves on a completed beat.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_cnt     <= 4'd0;
            r_hold    <= 1'b0;
            r_addr    <= '0;
            r_no_port <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_hold <= w_hold_nxt;
            if (bus.HREADYM) begin
                r_addr    <= w_addr_nxt;
                r_no_port <= w_no_port_nxt;
            end
        end
    end

    // Burst tracker next state.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_hold_nxt = r_hold;
        if (bus.HREADYM) begin
            if (!bus.HSELM) begin
                w_cnt_nxt  = 4'd0;
                w_hold_nxt = 1'b0;
            end else begin
                case (bus.HTRANSM)
                    TR_NONSEQ: begin
                        case (bus.HBURSTM)
                            BU_INCR16, BU_WRAP16: begin
                                w_cnt_nxt  = 4'd15;
                                w_hold_nxt = 1'b1;
                            end
                            BU_INCR8, BU_WRAP8: begin
                                w_cnt_nxt  = 4'd7;
                                w_hold_nxt = 1'b1;
                            end
                            BU_INCR4, BU_WRAP4: begin
                                w_cnt_nxt  = 4'd3;
                                w_hold_nxt = 1'b1;
                            end
                            default: begin
                                w_cnt_nxt  = 4'd0;
                                w_hold_nxt = 1'b0;
                            end
                        endcase
                    end
                    TR_SEQ: begin
                        w_cnt_nxt = r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            w_hold_nxt = 1'b0;
                        end
                    end
                    TR_BUSY: begin
                        w_cnt_nxt  = r_cnt;
                        w_hold_nxt = r_hold;
                    end
                    TR_IDLE: begin
                        w_cnt_nxt  = 4'd0;
                        w_hold_nxt = 1'b0;
                    end
                    default: begin
                        w_cnt_nxt  = r_cnt;
                        w_hold_nxt = r_hold;
                    end
                endcase
            end
        end
    end

    // Search last+1 .. last+NUM_PORTS, so the current holder has the lowest priority.
    always_comb begin
        w_rr_idx   = r_addr;
        w_rr_found = 1'b0;
        w_cand     = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = int'(r_addr) + k;
            if (w_cand >= NUM_PORTS) begin
                w_cand = w_cand - NUM_PORTS;
            end
            if (!w_rr_found && bus.req_port[PORT_W'(w_cand)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = PORT_W'(w_cand);
            end
        end
    end

    // Next grant: the burst/lock hold uses the next hold value, so the last SEQ beat can hand over.
    always_comb begin
        w_addr_nxt    = r_addr;
        w_no_port_nxt = r_no_port;
        if (bus.HMASTLOCKM || w_hold_nxt) begin
            w_no_port_nxt = 1'b0;
        end else if (w_rr_found) begin
            w_addr_nxt    = w_rr_idx;
            w_no_port_nxt = 1'b0;
        end else if (bus.HSELM) begin
            w_no_port_nxt = 1'b0;
        end else begin
            w_no_port_nxt = 1'b1;
        end
    end

    always_comb begin
        bus.addr_in_port = r_addr;
        bus.no_port      = r_no_port;
        bus.burst_hold   = r_hold;
    end

endmodule

// File: tb/tb_ahb_rr_output_arbiter.sv
// Scoreboard bench for ahb_rr_output_arbiter: a beat-level reference model predicts every post-edge output.
// A separate monitor compares each prediction against the DUT.
module tb_ahb_rr_output_arbiter;

    localparam int N = 4;

    logic HCLK;
    logic HRESET;

    ahb_rr_output_arbiter_if #(.NUM_PORTS(N), .PORT_W(2)) bus ();

    ahb_rr_output_arbiter #(.NUM_PORTS(N), .PORT_W(2)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    // Reference model state: owner, idle flag, and remaining beats of the current fixed burst.
    int m_addr  = 0;
    bit m_nop   = 1'b1;
    bit m_inb   = 1'b0;
    int m_left  = 0;

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge HCLK);
            if (HRESET) begin
                m_addr = 0;
                m_nop  = 1'b1;
                m_inb  = 1'b0;
                m_left = 0;
            end else if (bus.HREADYM) begin
                if (!bus.HSELM) begin
                    m_inb = 1'b0;
                end else if (bus.HTRANSM == 2'b10) begin
                    m_left = burst_len(bus.HBURSTM) - 1;
                    m_inb  = (m_left > 0);
                end else if (bus.HTRANSM == 2'b11) begin
                    if (m_inb) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_inb = 1'b0;
                    end
                end else if (bus.HTRANSM == 2'b00) begin
                    m_inb = 1'b0;
                end
                if (bus.HMASTLOCKM || m_inb) begin
                    m_nop = 1'b0;
                end else if (bus.req_port != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (bus.req_port[(m_addr + k) % N]) begin
                            m_addr = (m_addr + k) % N;
                            break;
                        end
                    end
                    m_nop = 1'b0;
                end else begin
                    m_nop = !bus.HSELM;
                end
            end
            exp_q.push_back({m_addr[1:0], m_nop, m_inb});
        end
    end

    initial begin
        logic [3:0] e;
        logic [3:0] a;
        forever begin
            @(posedge HCLK);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                a = {bus.addr_in_port, bus.no_port, bus.burst_hold};
                if (a !== e) begin
                    errors++;
                    $display("FAIL grant_state at %0t: got addr=%0d no_port=%0b hold=%0b, expected addr=%0d no_port=%0b hold=%0b",
                             $time, a[3:2], a[1], a[0], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] rq, input logic rdy, input logic sel,
                         input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        bus.req_port   = rq;
        bus.HREADYM    = rdy;
        bus.HSELM      = sel;
        bus.HTRANSM    = tr;
        bus.HBURSTM    = bu;
        bus.HMASTLOCKM = lk;
        @(negedge HCLK);
    endtask

    initial begin
        HRESET = 1'b1;
        drive(4'b1111, 1, 1, 2'b10, 3'b000, 0);
        drive(4'b1111, 1, 1, 2'b10, 3'b000, 0);
        HRESET = 1'b0;

        // Rotation over single transfers.
        repeat (6) drive(4'b1111, 1, 1, 2'b10, 3'b000, 0);

        // INCR4 from port 2 while 0,1,3 also request.
        drive(4'b1011, 1, 1, 2'b10, 3'b011, 0);
        repeat (3) drive(4'b1011, 1, 1, 2'b11, 3'b011, 0);

        // WRAP8 with three wait states at beat 4.
        drive(4'b1111, 1, 1, 2'b10, 3'b100, 0);
        repeat (3) drive(4'b1111, 1, 1, 2'b11, 3'b100, 0);
        repeat (3) drive(4'b1111, 0, 1, 2'b11, 3'b100, 0);
        repeat (4) drive(4'b1111, 1, 1, 2'b11, 3'b100, 0);
        drive(4'b1111, 1, 1, 2'b10, 3'b000, 0);

        // Locked sequence with IDLE and SINGLE transfers.
        drive(4'b1111, 1, 1, 2'b00, 3'b000, 1);
        drive(4'b1111, 1, 1, 2'b10, 3'b000, 1);
        drive(4'b1111, 1, 1, 2'b00, 3'b000, 1);
        drive(4'b1111, 1, 1, 2'b10, 3'b000, 1);
        drive(4'b1111, 1, 1, 2'b10, 3'b000, 1);
        repeat (3) drive(4'b1111, 1, 1, 2'b10, 3'b000, 0);

        // Idle release, then INCR16 reset at cnt=9.
        drive(4'b0000, 1, 0, 2'b00, 3'b000, 0);
        drive(4'b0000, 1, 1, 2'b00, 3'b000, 0);
        drive(4'b0100, 1, 1, 2'b10, 3'b111, 0);
        repeat (6) drive(4'b1111, 1, 1, 2'b11, 3'b111, 0);
        HRESET = 1'b1;
        drive(4'b1111, 1, 1, 2'b11, 3'b111, 0);
        HRESET = 1'b0;
        drive(4'b1111, 1, 1, 2'b11, 3'b111, 0);

        // Random well-formed bursts with waits, BUSY and occasional lock.
        for (int i = 0; i < 250; i++) begin
            logic [2:0] bu;
            int len;
            bu  = 3'($urandom_range(0, 7));
            len = burst_len(bu);
            drive(4'($urandom), 1'($urandom_range(0, 3) != 0), 1, 2'b10, bu,
                  1'($urandom_range(0, 9) == 0));
            for (int b = 1; b < len; b++) begin
                logic [1:0] tr;
                tr = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b11;
                drive(4'($urandom), 1'($urandom_range(0, 3) != 0), 1, tr, bu,
                      1'($urandom_range(0, 9) == 0));
            end
        end

        // Fully random cycles, including rare resets and deselects.
        for (int i = 0; i < 1500; i++) begin
            HRESET = ($urandom_range(0, 149) == 0);
            drive(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) != 0),
                  2'($urandom), 3'($urandom), 1'($urandom_range(0, 11) == 0));
        end
        HRESET = 1'b0;

        drive(4'b0000, 1, 0, 2'b00, 3'b000, 0);
        drive(4'b0000, 1, 0, 2'b00, 3'b000, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
